// File: rtl/pe_conv_scheduler.sv
// Sequences one processing element through an output feature map:
// clear accumulator, stream weight/activation reads, drain the PE pipe, write the result.
module pe_conv_scheduler #(
    parameter int NON_ZERO_WEIGHTS = 27,
    parameter int NUM_OUTPUTS      = 1024,
    parameter int ACT_STRIDE       = 1,
    parameter int PIPE_LAT         = 4,
    parameter int ADDR_W           = 16,
    parameter int BIT_SIZE         = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   act_base,
    input  logic [ADDR_W-1:0]   wgt_base,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   act_addr,
    output logic [ADDR_W-1:0]   wgt_addr,
    output logic                pe_clr_n,
    input  logic [BIT_SIZE-1:0] pe_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [BIT_SIZE-1:0] out_data,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state_dbg
);

    // Output handshake: a word transfers on a cycle where out_valid && out_ready;
    // out_valid, out_addr and out_data are held unchanged until that cycle.

    localparam int CNT_MAX = (NON_ZERO_WEIGHTS > PIPE_LAT) ? NON_ZERO_WEIGHTS : PIPE_LAT;
    localparam int KW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(NUM_OUTPUTS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q;
    logic [PW-1:0]       pix_q;
    logic [ADDR_W-1:0]   act_base_q, wgt_base_q;
    logic [BIT_SIZE-1:0] out_data_q;

    logic feed_last, drain_last, pix_last;

    assign feed_last  = (k_q == KW'(NON_ZERO_WEIGHTS - 1));
    assign drain_last = (k_q == KW'(PIPE_LAT - 1));
    assign pix_last   = (pix_q == PW'(NUM_OUTPUTS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (feed_last) state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = WRITE;
            WRITE:   if (out_ready) state_d = pix_last ? FIN : CLEAR;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // k is shared: tap index in FEED, pipeline wait count in DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q        <= '0;
            pix_q      <= '0;
            act_base_q <= '0;
            wgt_base_q <= '0;
            out_data_q <= '0;
        end else if (abort) begin
            k_q   <= '0;
            pix_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        act_base_q <= act_base;
                        wgt_base_q <= wgt_base;
                        pix_q      <= '0;
                        k_q        <= '0;
                    end
                end
                FEED:  k_q <= feed_last ? '0 : k_q + KW'(1);
                DRAIN: begin
                    k_q <= drain_last ? '0 : k_q + KW'(1);
                    if (drain_last) out_data_q <= pe_out;
                end
                WRITE: begin
                    if (out_ready) pix_q <= pix_last ? '0 : pix_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by abort in the same cycle so an aborted word is never accepted.
    always_comb begin
        busy      = (state_q != IDLE);
        rd_en     = (state_q == FEED) && !abort;
        pe_clr_n  = (state_q != IDLE) && (state_q != CLEAR) && !abort;
        out_valid = (state_q == WRITE) && !abort;
        done      = (state_q == FIN) && !abort;
        act_addr  = '0;
        wgt_addr  = '0;
        out_addr  = '0;
        if (state_q == FEED) begin
            act_addr = act_base_q + ADDR_W'(pix_q) * ADDR_W'(ACT_STRIDE) + ADDR_W'(k_q);
            wgt_addr = wgt_base_q + ADDR_W'(k_q);
        end
        if (state_q == WRITE) out_addr = ADDR_W'(pix_q);
    end

    assign out_data  = out_data_q;
    assign state_dbg = state_q;

endmodule
